rv0_ahb_ram_completer: RTL and testbench
========================================

// Module: rv0_ahb_ram_completer
// PURPOSE
// - AHB-Lite completer fronting an on-chip word-organised RAM; the memory-side end of the core's AHB requester ports.
// - Serves instruction fetch or load/store traffic at BASE_ADDR.
// - Provides a zero-wait-state pipelined response, or a fixed number of wait states.
// - Returns a two-cycle ERROR response for illegal transfers.
// PARAMETERS
// ADDR_WIDTH   32            haddr width
// DATA_WIDTH   32            hwdata/hrdata width (32 or 64); STRB_WIDTH = DATA_WIDTH/8
// MEM_DEPTH    4096          RAM depth in DATA_WIDTH words (power of 2)
// BASE_ADDR    'h0010_0000   first byte address served; aligned to MEM_DEPTH*STRB_WIDTH
// WAIT_STATES  0             extra data-phase cycles per OKAY transfer (0..7)
// PORTS
// clk        in   1           clock, rising edge
// rst        in   1           asynchronous active-high reset
// hsel       in   1           completer select
// haddr      in   ADDR_WIDTH  byte address (address phase)
// htrans     in   2           IDLE/BUSY/NONSEQ/SEQ (ahb_uvc_htrans_e)
// hsize      in   3           transfer size (ahb_uvc_hsize_e)
// hwrite     in   1           1 = write
// hexcl      in   1           exclusive request (unsupported)
// hwdata     in   DATA_WIDTH  write data (data phase)
// hwstrb     in   STRB_WIDTH  write byte strobes (data phase)
// hrdata     out  DATA_WIDTH  read data, valid when hreadyout=1 and hresp=0
// hreadyout  out  1           data phase complete; also the system hready
// hresp      out  1           0 = OKAY, 1 = ERROR
// hexokay    out  1           tied 0
// BEHAVIOUR
// - Reset values: hreadyout=1, hresp=0, hrdata=0, hexokay=0, FSM=IDLE, no pending write.
// - Accept rule: a transfer is accepted on a rising edge with hsel & htrans[1] & hreadyout.
//   - IDLE/BUSY or !hsel: no data phase is opened; the next cycle gives OKAY with zero wait.
// - Legality check in the address phase; ERROR if any of:
//   - haddr is outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*STRB_WIDTH);
//   - hsize > log2(STRB_WIDTH);
//   - haddr is not aligned to 2**hsize;
//   - hexcl=1.
// - FSM states and transitions:
//   - IDLE: no data phase pending.
//   - DATA: counts WAIT_STATES with hreadyout=0.
//     - Legal accept in IDLE/DATA-last -> DATA, or back-to-back DATA.
//     - Counter 0 -> hreadyout=1, resp OKAY.
//   - ERR1: hreadyout=0, hresp=1. Illegal accept -> ERR1 -> ERR2.
//   - ERR2: hreadyout=1, hresp=1. ERR2 samples a new address phase like IDLE.
//     - The requester may cancel by driving IDLE in ERR2.
// - Read latency:
//   - RAM read is issued on the accept edge.
//   - hrdata is valid in the first data-phase cycle with WAIT_STATES=0, else after WAIT_STATES cycles.
//   - hrdata is held stable while hreadyout=0.
//   - hrdata drives the full word; the requester selects lanes.
// - Writes:
//   - Byte enables = hwstrb AND the lane mask derived from haddr/hsize.
//   - The write commits to RAM on the final data-phase edge (hreadyout=1); an ERROR transfer never writes.
// - Read-after-write:
//   - A read accepted on the same edge a write commits to the same word returns the byte-merged new data, i.e. it is forwarded.
//   - Other bytes come from RAM.
// - Pipelining:
//   - The address phase of transfer N+1 overlaps the data phase of N.
//   - No extra bubbles with WAIT_STATES=0: one transfer per cycle.
// - Mid-operation reset forces IDLE; an uncommitted write is dropped; RAM contents are not cleared.
// - RAM index = (haddr-BASE_ADDR) >> log2(STRB_WIDTH); the subtraction is done at ADDR_WIDTH and overflow is impossible after the range check.
// STRUCTURE
// - Shared rv0_core_defs:
//   - reuse ahb_uvc_htrans_e, ahb_uvc_hsize_e, ahb_uvc_hresp_e;
//   - add the typedef struct ahb_aphase_t {addr, size, write, ok} to the shared defs.
// - The FSM state enum stays local.
// - One sub-module: rv0_sram_1r1w (sync read, byte-enable write, MEM_DEPTH x DATA_WIDTH).
// TESTING
// - Reset: assert rst mid-write to 'h0010_0000 -> hreadyout=1, hresp=0, hrdata=0; a read back returns the old value.
// - Back-to-back traffic, WAIT_STATES=0:
//   - stimulus: word write 'hDEADBEEF @'h0010_0004, then read @'h0010_0004 in consecutive cycles;
//   - required response: the read returns 'hDEADBEEF with no wait state (forwarding).
// - Byte write:
//   - stimulus: hsize=BYTE @'h0010_0006 with hwdata='hAABBCCDD and hwstrb='hF;
//   - required response: only lane 2 is written; a word read gives 'hDEBBBEEF.
// - Out of range:
//   - stimulus: read @'h0000_0000;
//   - required response: hreadyout 0 then 1 with hresp=1 both cycles; the next legal transfer gets OKAY.
// - Misaligned access: HALF write @'h0010_0001 -> ERROR; RAM is unchanged.
// - Wait states:
//   - stimulus: WAIT_STATES=2, read;
//   - required response: hreadyout low for exactly 2 cycles, then data, with hrdata stable throughout.

Source files
------------

// File: rtl/rv0_core_defs_pkg.sv
// Shared AHB-Lite type definitions used by the core's bus requesters and completers.
package rv0_core_defs;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } ahb_uvc_htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'd0,
      HSIZE_HALF  = 3'd1,
      HSIZE_WORD  = 3'd2,
      HSIZE_DWORD = 3'd3,
      HSIZE_4W    = 3'd4,
      HSIZE_8W    = 3'd5,
      HSIZE_16W   = 3'd6,
      HSIZE_32W   = 3'd7
   } ahb_uvc_hsize_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } ahb_uvc_hresp_e;

   localparam int unsigned AHB_ADDR_MAX = 64;

   // Captured address phase; addr is zero-extended so one type serves every bus width.
   typedef struct packed {
      logic [AHB_ADDR_MAX-1:0] addr;
      ahb_uvc_hsize_e          size;
      logic                    write;
      logic                    ok;
   } ahb_aphase_t;

endpackage

// File: rtl/rv0_sram_1r1w.sv
// Word-organised RAM: synchronous read, byte-enable write, same-edge write-to-read forwarding.
module rv0_sram_1r1w #(
   parameter int unsigned DEPTH      = 4096,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_BITS  = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    re,
   input  logic [ADDR_BITS-1:0]    raddr,
   output logic [DATA_WIDTH-1:0]   rdata,
   input  logic                    we,
   input  logic [ADDR_BITS-1:0]    waddr,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic [DATA_WIDTH-1:0]   wdata
);

   localparam int unsigned NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Bytes written on the same edge as the read are taken from wdata, the rest from the array.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         for (int unsigned b = 0; b < NB; b++) begin
            rdata[8*b +: 8] <= (we && wbe[b] && (waddr == raddr)) ? wdata[8*b +: 8]
                                                                  : mem[raddr][8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/rv0_ahb_ram_completer.sv
// AHB-Lite completer in front of an on-chip RAM: pipelined OKAY with optional wait states,
// two-cycle ERROR for out-of-range, oversized, misaligned or exclusive transfers.
module rv0_ahb_ram_completer
   import rv0_core_defs::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           MEM_DEPTH   = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h0010_0000,
   parameter int unsigned           WAIT_STATES = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hsel,
   input  logic [ADDR_WIDTH-1:0]   haddr,
   input  logic [1:0]              htrans,
   input  logic [2:0]              hsize,
   input  logic                    hwrite,
   input  logic                    hexcl,
   input  logic [DATA_WIDTH-1:0]   hwdata,
   input  logic [DATA_WIDTH/8-1:0] hwstrb,
   output logic [DATA_WIDTH-1:0]   hrdata,
   output logic                    hreadyout,
   output logic                    hresp,
   output logic                    hexokay
);

   localparam int unsigned         STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned         LOG2_STRB  = $clog2(STRB_WIDTH);
   localparam int unsigned         IDX_W      = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH:0] SPAN       = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_e;

   state_e                  state_q, state_d;
   logic [2:0]              cnt_q, cnt_d;
   ahb_aphase_t             ap, dp_q;
   ahb_uvc_hresp_e          resp;
   logic [ADDR_WIDTH-1:0]   aoff, doff;
   logic                    accept, in_range, size_ok, misaligned;
   logic [STRB_WIDTH-1:0]   lane_mask, wbe;
   logic                    ram_we, ram_re;
   logic                    unused_sink;

   // Address-phase legality.
   always_comb begin
      aoff       = haddr - BASE_ADDR;
      in_range   = (haddr >= BASE_ADDR) && ({1'b0, aoff} < SPAN);
      size_ok    = 32'(hsize) <= LOG2_STRB;
      misaligned = 1'b0;
      for (int unsigned i = 0; i < 7; i++) begin
         if (i < 32'(hsize) && haddr[i]) misaligned = 1'b1;
      end
      ap.addr  = AHB_ADDR_MAX'(haddr);
      ap.size  = ahb_uvc_hsize_e'(hsize);
      ap.write = hwrite;
      ap.ok    = in_range && size_ok && !misaligned && !hexcl;
   end

   always_comb begin
      hreadyout = 1'b1;
      resp      = HRESP_OKAY;
      state_d   = state_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_DATA:  hreadyout = (cnt_q == 3'd0);
         S_ERR1: begin
            hreadyout = 1'b0;
            resp      = HRESP_ERROR;
         end
         S_ERR2:  resp = HRESP_ERROR;
         default: ;
      endcase
      accept = hsel && htrans[1] && hreadyout;
      if (state_q == S_ERR1) begin
         state_d = S_ERR2;
      end else if (hreadyout) begin
         if (accept && ap.ok) begin
            state_d = S_DATA;
            cnt_d   = 3'(WAIT_STATES);
         end else if (accept) begin
            state_d = S_ERR1;
         end else begin
            state_d = S_IDLE;
         end
      end else begin
         cnt_d = cnt_q - 3'd1;
      end
   end

   assign hresp   = resp;
   assign hexokay = 1'b0;

   // Data-phase lane mask: byte b is enabled when it lies in the same 2**size chunk as the address.
   always_comb begin
      doff = dp_q.addr[ADDR_WIDTH-1:0] - BASE_ADDR;
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
         lane_mask[b] = (b >> dp_q.size) == (32'(doff[LOG2_STRB-1:0]) >> dp_q.size);
      end
      wbe = hwstrb & lane_mask;
   end

   assign ram_we = (state_q == S_DATA) && (cnt_q == 3'd0) && dp_q.write;
   assign ram_re = accept && ap.ok && !hwrite;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dp_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) dp_q <= ap;
      end
   end

   rv0_sram_1r1w #(
      .DEPTH      (MEM_DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (IDX_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .re    (ram_re),
      .raddr (aoff[IDX_W+LOG2_STRB-1:LOG2_STRB]),
      .rdata (hrdata),
      .we    (ram_we),
      .waddr (doff[IDX_W+LOG2_STRB-1:LOG2_STRB]),
      .wbe   (wbe),
      .wdata (hwdata)
   );

   assign unused_sink = ^{htrans[0], dp_q, aoff, doff};

endmodule

// File: tb/tb_rv0_ahb_ram_completer.sv
// Directed bench: one zero-wait completer for the main traffic, one two-wait-state completer.
module tb_rv0_ahb_ram_completer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        hsel_a, hwrite_a, hexcl_a, hreadyout_a, hresp_a, hexokay_a;
   logic [31:0] haddr_a, hwdata_a, hrdata_a;
   logic [1:0]  htrans_a;
   logic [2:0]  hsize_a;
   logic [3:0]  hwstrb_a;

   logic        hsel_b, hwrite_b, hexcl_b, hreadyout_b, hresp_b, hexokay_b;
   logic [31:0] haddr_b, hwdata_b, hrdata_b;
   logic [1:0]  htrans_b;
   logic [2:0]  hsize_b;
   logic [3:0]  hwstrb_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rv0_ahb_ram_completer #(.WAIT_STATES(0)) dut_a (
      .clk(clk), .rst(rst), .hsel(hsel_a), .haddr(haddr_a), .htrans(htrans_a),
      .hsize(hsize_a), .hwrite(hwrite_a), .hexcl(hexcl_a), .hwdata(hwdata_a),
      .hwstrb(hwstrb_a), .hrdata(hrdata_a), .hreadyout(hreadyout_a),
      .hresp(hresp_a), .hexokay(hexokay_a)
   );

   rv0_ahb_ram_completer #(.WAIT_STATES(2)) dut_b (
      .clk(clk), .rst(rst), .hsel(hsel_b), .haddr(haddr_b), .htrans(htrans_b),
      .hsize(hsize_b), .hwrite(hwrite_b), .hexcl(hexcl_b), .hwdata(hwdata_b),
      .hwstrb(hwstrb_b), .hrdata(hrdata_b), .hreadyout(hreadyout_b),
      .hresp(hresp_b), .hexokay(hexokay_b)
   );

   task step();
      @(posedge clk);
      #1;
   endtask

   task a_addr(input logic [31:0] addr, input logic [2:0] size, input logic wr, input logic excl);
      hsel_a = 1'b1; htrans_a = 2'b10; haddr_a = addr; hsize_a = size; hwrite_a = wr; hexcl_a = excl;
   endtask

   task a_idle();
      hsel_a = 1'b0; htrans_a = 2'b00; haddr_a = '0; hsize_a = 3'd2; hwrite_a = 1'b0; hexcl_a = 1'b0;
   endtask

   task b_addr(input logic [31:0] addr, input logic [2:0] size, input logic wr);
      hsel_b = 1'b1; htrans_b = 2'b10; haddr_b = addr; hsize_b = size; hwrite_b = wr; hexcl_b = 1'b0;
   endtask

   task b_idle();
      hsel_b = 1'b0; htrans_b = 2'b00; haddr_b = '0; hsize_b = 3'd2; hwrite_b = 1'b0; hexcl_b = 1'b0;
   endtask

   task test_reset();
      a_idle(); b_idle();
      hwdata_a = '0; hwstrb_a = '0; hwdata_b = '0; hwstrb_b = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (hreadyout_a !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", hreadyout_a); end
      checks++; if (hresp_a !== 1'b0) begin failures++; $display("FAIL reset_resp got=%0b exp=0", hresp_a); end
      checks++; if (hrdata_a !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", hrdata_a); end
      checks++; if (hexokay_a !== 1'b0) begin failures++; $display("FAIL reset_exokay got=%0b exp=0", hexokay_a); end
      checks++; if (hreadyout_b !== 1'b1) begin failures++; $display("FAIL reset_ready_ws got=%0b exp=1", hreadyout_b); end
      rst = 1'b0;
      step();
   endtask

   task test_back_to_back();
      a_addr(32'h0010_0004, 3'd2, 1'b1, 1'b0);
      step();
      checks++; if (hreadyout_a !== 1'b1 || hresp_a !== 1'b0) begin failures++; $display("FAIL b2b_wr_phase got=%0b/%0b exp=1/0", hreadyout_a, hresp_a); end
      hwdata_a = 32'hDEAD_BEEF; hwstrb_a = 4'hF;
      a_addr(32'h0010_0004, 3'd2, 1'b0, 1'b0);
      step();
      a_idle();
      checks++; if (hreadyout_a !== 1'b1 || hresp_a !== 1'b0) begin failures++; $display("FAIL b2b_rd_phase got=%0b/%0b exp=1/0", hreadyout_a, hresp_a); end
      checks++; if (hrdata_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_fwd_data got=%h exp=deadbeef", hrdata_a); end
      step();
   endtask

   task test_byte_write();
      a_addr(32'h0010_0006, 3'd0, 1'b1, 1'b0);
      step();
      hwdata_a = 32'hAABB_CCDD; hwstrb_a = 4'hF;
      a_addr(32'h0010_0004, 3'd2, 1'b0, 1'b0);
      step();
      a_idle();
      checks++; if (hrdata_a !== 32'hDEBB_BEEF) begin failures++; $display("FAIL byte_fwd_data got=%h exp=debbbeef", hrdata_a); end
      a_addr(32'h0010_0004, 3'd2, 1'b0, 1'b0);
      step();
      a_idle();
      checks++; if (hrdata_a !== 32'hDEBB_BEEF) begin failures++; $display("FAIL byte_ram_data got=%h exp=debbbeef", hrdata_a); end
      step();
   endtask

   task test_out_of_range();
      a_addr(32'h0000_0000, 3'd2, 1'b0, 1'b0);
      step();
      checks++; if (hreadyout_a !== 1'b0 || hresp_a !== 1'b1) begin failures++; $display("FAIL oor_err1 got=%0b/%0b exp=0/1", hreadyout_a, hresp_a); end
      a_idle();
      step();
      checks++; if (hreadyout_a !== 1'b1 || hresp_a !== 1'b1) begin failures++; $display("FAIL oor_err2 got=%0b/%0b exp=1/1", hreadyout_a, hresp_a); end
      a_addr(32'h0010_0004, 3'd2, 1'b0, 1'b0);
      step();
      a_idle();
      checks++; if (hreadyout_a !== 1'b1 || hresp_a !== 1'b0) begin failures++; $display("FAIL oor_next_okay got=%0b/%0b exp=1/0", hreadyout_a, hresp_a); end
      checks++; if (hrdata_a !== 32'hDEBB_BEEF) begin failures++; $display("FAIL oor_next_data got=%h exp=debbbeef", hrdata_a); end
      step();
   endtask

   task test_reset_mid_write();
      a_addr(32'h0010_0000, 3'd2, 1'b1, 1'b0);
      step();
      hwdata_a = 32'h1122_3344; hwstrb_a = 4'hF;
      a_idle();
      step();
      a_addr(32'h0010_0000, 3'd2, 1'b1, 1'b0);
      step();
      hwdata_a = 32'h5566_7788;
      a_idle();
      #2 rst = 1'b1;
      #1;
      checks++; if (hreadyout_a !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%0b exp=1", hreadyout_a); end
      checks++; if (hresp_a !== 1'b0) begin failures++; $display("FAIL rst_mid_resp got=%0b exp=0", hresp_a); end
      checks++; if (hrdata_a !== 32'h0) begin failures++; $display("FAIL rst_mid_rdata got=%h exp=00000000", hrdata_a); end
      step();
      rst = 1'b0;
      step();
      a_addr(32'h0010_0000, 3'd2, 1'b0, 1'b0);
      step();
      a_idle();
      checks++; if (hrdata_a !== 32'h1122_3344) begin failures++; $display("FAIL rst_mid_readback got=%h exp=11223344", hrdata_a); end
      step();
   endtask

   task test_misaligned();
      a_addr(32'h0010_0001, 3'd1, 1'b1, 1'b0);
      step();
      checks++; if (hreadyout_a !== 1'b0 || hresp_a !== 1'b1) begin failures++; $display("FAIL misal_err1 got=%0b/%0b exp=0/1", hreadyout_a, hresp_a); end
      hwdata_a = 32'hFFFF_FFFF; hwstrb_a = 4'hF;
      a_idle();
      step();
      checks++; if (hreadyout_a !== 1'b1 || hresp_a !== 1'b1) begin failures++; $display("FAIL misal_err2 got=%0b/%0b exp=1/1", hreadyout_a, hresp_a); end
      step();
      a_addr(32'h0010_0000, 3'd2, 1'b0, 1'b0);
      step();
      a_idle();
      checks++; if (hrdata_a !== 32'h1122_3344) begin failures++; $display("FAIL misal_ram_kept got=%h exp=11223344", hrdata_a); end
      step();
   endtask

   task test_legality();
      logic [31:0] t_addr [7] = '{32'h0010_3FFC, 32'h0010_4000, 32'h000F_FFFC, 32'h0010_0008,
                                  32'h0010_0008, 32'h0010_0002, 32'h0010_0002};
      logic [2:0]  t_size [7] = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd2, 3'd1, 3'd2};
      logic        t_excl [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic        t_err  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 7; i++) begin
         a_addr(t_addr[i], t_size[i], 1'b0, t_excl[i]);
         step();
         a_idle();
         checks++; if (hreadyout_a !== !t_err[i] || hresp_a !== t_err[i]) begin
            failures++; $display("FAIL legal_ph1[%0d] got=%0b/%0b exp=%0b/%0b", i, hreadyout_a, hresp_a, !t_err[i], t_err[i]);
         end
         step();
         checks++; if (hreadyout_a !== 1'b1 || hresp_a !== t_err[i]) begin
            failures++; $display("FAIL legal_ph2[%0d] got=%0b/%0b exp=1/%0b", i, hreadyout_a, hresp_a, t_err[i]);
         end
         step();
      end
   endtask

   task test_wait_states();
      b_addr(32'h0010_0008, 3'd2, 1'b1);
      step();
      checks++; if (hreadyout_b !== 1'b0) begin failures++; $display("FAIL ws_wr_wait1 got=%0b exp=0", hreadyout_b); end
      hwdata_b = 32'hCAFE_F00D; hwstrb_b = 4'hF;
      b_addr(32'h0010_0008, 3'd2, 1'b0);
      step();
      checks++; if (hreadyout_b !== 1'b0) begin failures++; $display("FAIL ws_wr_wait2 got=%0b exp=0", hreadyout_b); end
      step();
      checks++; if (hreadyout_b !== 1'b1 || hresp_b !== 1'b0) begin failures++; $display("FAIL ws_wr_done got=%0b/%0b exp=1/0", hreadyout_b, hresp_b); end
      step();
      b_idle();
      for (int c = 0; c < 3; c++) begin
         checks++; if (hreadyout_b !== (c == 2) || hresp_b !== 1'b0) begin
            failures++; $display("FAIL ws_rd_ready[%0d] got=%0b/%0b exp=%0b/0", c, hreadyout_b, hresp_b, (c == 2));
         end
         checks++; if (hrdata_b !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL ws_rd_data[%0d] got=%h exp=cafef00d", c, hrdata_b);
         end
         step();
      end
      checks++; if (hreadyout_b !== 1'b1) begin failures++; $display("FAIL ws_idle_ready got=%0b exp=1", hreadyout_b); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_byte_write();
      test_out_of_range();
      test_reset_mid_write();
      test_misaligned();
      test_legality();
      test_wait_states();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
